// File: rtl/inter_pred_idc_ctx_fifo.sv
// Tags inter_pred_idc bins with ctxInc/last, queues them for the CABAC engine, and flags count/sequencing errors.
// Push lands at the bin edge with head visible next cycle; full FIFO drops bins (sticky overflow) unless popped same cycle.
module inter_pred_idc_ctx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    nPbW,
  input  logic [3:0]    nPbH,
  input  logic [1:0]    ct_depth,
  input  logic          bin_valid,
  input  logic          bin_value,
  input  logic          done,
  input  logic [1:0]    num_bins,
  output logic          ce_valid,
  input  logic          ce_ready,
  output logic          ce_bin,
  output logic [2:0]    ce_ctx_inc,
  output logic          ce_last,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          overflow,
  output logic          protocol_err
);

  typedef enum logic [1:0] {IDLE, BIN0, BIN1} state_t;

  state_t      state, state_nx, cur_state;
  logic        small_q, small_nx, cur_small;
  logic [1:0]  ctd_q, ctd_nx, cur_ctd;
  logic [1:0]  cnt_q, cnt_nx, cnt_base;
  logic        push, err_set;
  logic [4:0]  push_dat;

  // A start in the same cycle as a bin re-arms first, so the bin sees the new element's context.
  always_comb begin
    state_nx  = state;
    small_nx  = small_q;
    ctd_nx    = ctd_q;
    cnt_nx    = cnt_q;
    push      = 1'b0;
    push_dat  = 5'd0;
    err_set   = 1'b0;
    cur_state = state;
    cur_small = small_q;
    cur_ctd   = ctd_q;
    cnt_base  = cnt_q;

    if (start) begin
      small_nx  = (({1'b0, nPbW} + {1'b0, nPbH}) == 5'd12);
      ctd_nx    = ct_depth;
      cnt_nx    = 2'd0;
      state_nx  = BIN0;
      cur_state = BIN0;
      cur_small = small_nx;
      cur_ctd   = ctd_nx;
      cnt_base  = 2'd0;
      if (state != IDLE) err_set = 1'b1;
    end else if (done) begin
      if (cnt_q != num_bins) err_set = 1'b1;
      if (state != IDLE) begin
        err_set  = 1'b1;
        state_nx = IDLE;
      end
    end

    if (bin_valid) begin
      case (cur_state)
        BIN0: begin
          push   = 1'b1;
          cnt_nx = (cnt_base == 2'd3) ? 2'd3 : cnt_base + 2'd1;
          if (cur_small) begin
            push_dat = {bin_value, 3'd4, 1'b1};
            state_nx = IDLE;
          end else begin
            push_dat = {bin_value, 1'b0, cur_ctd, bin_value};
            state_nx = bin_value ? IDLE : BIN1;
          end
        end
        BIN1: begin
          push     = 1'b1;
          cnt_nx   = (cnt_base == 2'd3) ? 2'd3 : cnt_base + 2'd1;
          push_dat = {bin_value, 3'd4, 1'b1};
          state_nx = IDLE;
        end
        default: err_set = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      small_q <= 1'b0;
      ctd_q   <= 2'd0;
      cnt_q   <= 2'd0;
    end else begin
      state   <= state_nx;
      small_q <= small_nx;
      ctd_q   <= ctd_nx;
      cnt_q   <= cnt_nx;
    end
  end

  logic [4:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, pop, wr_en, drop;
  logic [4:0]  head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ce_valid & ce_ready;
  // The slot freed by a same-cycle pop is the one being written, so a full FIFO can still accept.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (drop)    overflow     <= 1'b1;
      if (err_set) protocol_err <= 1'b1;
    end
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign ce_valid   = ~empty;
  assign ce_bin     = ce_valid & head[4];
  assign ce_ctx_inc = ce_valid ? head[3:1] : 3'd0;
  assign ce_last    = ce_valid & head[0];
  assign level      = wr_ptr - rd_ptr;
  assign busy       = (state != IDLE);

endmodule

// File: doc/inter_pred_idc_ctx_fifo.md
# inter_pred_idc_ctx_fifo

Downstream companion of the `inter_pred_idc` binarizer. It consumes the binarizer's bin stream, tags each bin with its HEVC context increment (ctxInc), and marks the last bin of the syntax element. It buffers the tagged bins in a small FIFO and hands them to the CABAC arithmetic-coding engine over a valid/ready handshake. It also checks the binarizer's bin count and flags overflow and protocol errors.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Must be a power of two, at least 2.
- `AW`, $clog2(DEPTH): FIFO pointer width, derived.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  element start. Same pulse that starts the binarizer.
- `nPbW`, `nPbH`  in  4 each  PB size. Sampled on `start`.
- `ct_depth`  in  2  CtDepth of the current CU. Sampled on `start`.
- `bin_valid`  in  1  binarizer bin strobe.
- `bin_value`  in  1  binarizer bin.
- `done`  in  1  binarizer element-complete pulse.
- `num_bins`  in  2  binarizer bin count, valid with `done`.
- `ce_valid`  out  1  FIFO head valid toward the CABAC engine.
- `ce_ready`  in  1  engine accepts the head.
- `ce_bin`  out  1  head bin value.
- `ce_ctx_inc`  out  3  head ctxInc, range 0..4.
- `ce_last`  out  1  head is the final bin of the element.
- `level`  out  AW+1  FIFO occupancy.
- `busy`  out  1  element armed and not yet complete.
- `overflow`  out  1  sticky. A bin was dropped because the FIFO was full.
- `protocol_err`  out  1  sticky. Bin-count or sequencing violation.

## Operation
- State machine `IDLE` -> `BIN0` -> `BIN1` -> `IDLE`.
  - `start` in any state latches `small = (nPbW + nPbH == 12)` (computed 5-bit, no wrap) and `ct_depth`, clears the bin counter, and goes to `BIN0`.
  - `start` while in `BIN0` or `BIN1` also sets `protocol_err`; the new element replaces the old one.
- Bin tagging on `bin_valid`:
  - `BIN0`, `small=0`: ctxInc = `ct_depth`. If bin=1, last=1 and go to `IDLE`. If bin=0, last=0 and go to `BIN1`.
  - `BIN0`, `small=1`: ctxInc = 4, last=1, go to `IDLE`.
  - `BIN1`: ctxInc = 4, last=1, go to `IDLE`.
  - `IDLE`: the bin is not written, and `protocol_err` is set.
- Count check:
  - An internal counter counts bins accepted since `start`.
  - On `done`, if the counter differs from `num_bins`, set `protocol_err`.
  - `done` in `BIN0` or `BIN1` (element not finished) also sets `protocol_err` and returns to `IDLE`.
  - `done` in `IDLE` after a completed element is legal.
- FIFO:
  - Each entry is {bin, ctxInc, last}, 5 bits. There are `DEPTH` entries.
  - Write and read pointers are AW+1 bits so full and empty are distinguishable.
  - Push happens when a tagged bin is produced. Pop happens when `ce_valid & ce_ready`.
  - Push while full:
    - With a simultaneous pop, the push succeeds and `level` is unchanged.
    - Without a pop, the bin is dropped, `overflow` is set, and the state machine still advances.
  - Pop while empty cannot occur because `ce_valid`=0.
  - Pointers wrap modulo 2·DEPTH.
- `busy` = state != `IDLE`.
- `overflow` and `protocol_err` clear only on reset.

## Timing
- Reset, asynchronous:
  - State goes to `IDLE` and pointers go to 0.
  - `ce_valid`=0, `ce_bin`=0, `ce_ctx_inc`=0, `ce_last`=0, `level`=0, `busy`=0, `overflow`=0, `protocol_err`=0.
  - Reset mid-element discards FIFO contents and any partial element.
- `start` to `busy`=1: 1 cycle (registered).
- `bin_valid` in cycle N:
  - Entry is written at the N edge.
  - `ce_valid` and head fields reflect the entry from cycle N+1 if the FIFO was empty.
  - `level` updates at N+1.
- Head outputs are registered and stable while `ce_valid`=1 and `ce_ready`=0.
- A pop at edge N exposes the next entry in cycle N+1, so throughput is 1 bin per cycle.
- `start` and `bin_valid` in the same cycle: `start` wins, and the bin is treated as a `BIN0` bin of the new element.
- Sticky flags assert 1 cycle after the offending event.

## Test plan
- Reset state, then start with 8x8, ct_depth=2, pred_idc=0 (bins 0,0), `ce_ready`=1:
  - Head sequence is {0,ctx2,last0}, {0,ctx4,last1}.
  - `busy` falls after the second bin; no errors.
- 8x8, ct_depth=1, BI (single bin 1):
  - One entry {1,ctx1,last1}.
  - `num_bins`=1 on `done` gives no error.
- 8x4 small block, L1 (bin 1):
  - One entry {1,ctx4,last1}.
  - A second bin strobe afterwards sets `protocol_err` and is not written.
- Hold `ce_ready`=0 and push DEPTH+1 bins across several elements:
  - `level`=DEPTH and `overflow`=1.
  - The first DEPTH entries drain intact in order once `ce_ready`=1.
- With the FIFO full, push and pop in the same cycle: `level` stays DEPTH and `overflow` stays 0.
- Two further error scenarios:
  - `done` with `num_bins`=2 after only one bin: `protocol_err`=1.
  - Assert `rst_n`=0 mid-element with 3 entries queued: `ce_valid`=0, `level`=0, and flags clear.
